// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and legal parameter ranges,
// intended to be reused by a future transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_rx_state_t;

   localparam int CLKS_PER_BIT_MIN = 4;
   localparam int CLKS_PER_BIT_MAX = 65535;
   localparam int DATA_BITS_MIN    = 5;
   localparam int DATA_BITS_MAX    = 9;
   localparam int STOP_BITS_MIN    = 1;
   localparam int STOP_BITS_MAX    = 2;

   // Wide enough to count data bits and stop bits of the largest legal frame.
   localparam int BIT_IDX_W = $clog2(DATA_BITS_MAX + 1);

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter for the UART receiver, giving half-bit and full-bit
// strobes; saturates at CLKS_PER_BIT so it never wraps inside a bit.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic restart_i,
   output logic halfTick_o,
   output logic fullTick_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Restart loads 1, not 0: the strobe cycle itself is the first elapsed
   // cycle of the next bit, so the bit period stays exactly CLKS_PER_BIT.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (restart_i) begin
         count_d = CNT_W'(1);
      end else if (count_q != FULL_CNT) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign halfTick_o = (count_q == HALF_CNT);
   assign fullTick_o = (count_q == FULL_CNT);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with ready/valid output and error pulses.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data.
import uart_pkg::*;

module uart_rx_param #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx_serial,
   input  logic                 i_ready,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_valid,
   output logic                 o_busy,
   output logic                 o_frame_err,
   output logic                 o_par_err,
   output logic                 o_overrun
);

   if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX ||
       DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
       STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParam
      $error("uart_rx_param: parameter out of legal range");
   end

   uart_rx_state_t       state_q, state_d;
   logic [1:0]           sync_q;
   logic                 rxSync;
   logic [BIT_IDX_W-1:0] bitIdx_q, bitIdx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 parBad_q, parBad_d;
   logic                 valid_q, valid_d;
   logic                 frameErr_q, frameErr_d;
   logic                 parErr_q, parErr_d;
   logic                 overrun_q, overrun_d;
   logic                 timerClear;
   logic                 timerRestart;
   logic                 halfTick;
   logic                 fullTick;

   assign rxSync = sync_q[1];

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uBitTimer (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .clear_i   (timerClear),
      .restart_i (timerRestart),
      .halfTick_o(halfTick),
      .fullTick_o(fullTick)
   );

   always_comb begin
      state_d      = state_q;
      bitIdx_d     = bitIdx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      parBad_d     = parBad_q;
      valid_d      = valid_q & ~i_ready;
      frameErr_d   = 1'b0;
      parErr_d     = 1'b0;
      overrun_d    = 1'b0;
      timerClear   = 1'b0;
      timerRestart = 1'b0;

      case (state_q)
         IDLE: begin
            timerClear = 1'b1;
            if (!rxSync) begin
               state_d  = START;
               bitIdx_d = '0;
               parBad_d = 1'b0;
            end
         end
         START: begin
            if (halfTick) begin
               if (!rxSync) begin
                  state_d      = DATA;
                  timerRestart = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (fullTick) begin
               timerRestart = 1'b1;
               shift_d      = {rxSync, shift_q[DATA_BITS-1:1]};
               bitIdx_d     = bitIdx_q + 1'b1;
               if (bitIdx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                  bitIdx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d  = PARITY;
`else
                  state_d  = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (fullTick) begin
               timerRestart = 1'b1;
               parBad_d     = (rxSync != ((^shift_q) ^ (PARITY_ODD != 0)));
               state_d      = STOP;
            end
         end
`endif
         STOP: begin
            if (fullTick) begin
               timerRestart = 1'b1;
               if (!rxSync) begin
                  frameErr_d = 1'b1;
                  state_d    = WAIT_IDLE;
               end else if (bitIdx_q == BIT_IDX_W'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  // A consumer accepting this very cycle frees the slot for the new word.
                  if (parBad_q) begin
                     parErr_d = 1'b1;
                  end else if (valid_q && !i_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            if (rxSync) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         parBad_q   <= 1'b0;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
         parErr_q   <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[0], i_rx_serial};
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         parBad_q   <= parBad_d;
         valid_q    <= valid_d;
         frameErr_q <= frameErr_d;
         parErr_q   <= parErr_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_rx_data   = data_q;
   assign o_valid     = valid_q;
   assign o_busy      = (state_q != IDLE);
   assign o_frame_err = frameErr_q;
   assign o_par_err   = parErr_q;
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard testbench for uart_rx_param at 16 clocks per bit, 8N1
// (adds parity frames when UART_RX_PARITY_EN is defined).
module tb_uart_rx_param;

   localparam int CPB        = 16;
   localparam int PARITY_ODD = 0;

   logic       clk;
   logic       rst;
   logic       rxSerial;
   logic       ready;
   logic [7:0] rxData;
   logic       valid;
   logic       busy;
   logic       frameErr;
   logic       parErr;
   logic       overrun;

   int         compareCount  = 0;
   int         mismatchCount = 0;
   int         validCycles    = 0;
   int         frameErrCycles = 0;
   int         parErrCycles   = 0;
   int         overrunCycles  = 0;
   logic       prevValid = 1'b0;
   logic [7:0] sbQ[$];

   uart_rx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .STOP_BITS   (1),
      .PARITY_ODD  (PARITY_ODD)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rx_serial(rxSerial),
      .i_ready    (ready),
      .o_rx_data  (rxData),
      .o_valid    (valid),
      .o_busy     (busy),
      .o_frame_err(frameErr),
      .o_par_err  (parErr),
      .o_overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic driveLine(input logic b);
      rxSerial = b;
      waitCycles(CPB);
   endtask

   // One frame LSB first; the line is left at the stop level on return.
   task automatic applyStimulus(input logic [7:0] d, input logic stopLevel);
      driveLine(1'b0);
      for (int i = 0; i < 8; i++) driveLine(d[i]);
`ifdef UART_RX_PARITY_EN
      driveLine((^d) ^ PARITY_ODD[0]);
`endif
      driveLine(stopLevel);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic sendParFrame(input logic [7:0] d, input logic parBit);
      driveLine(1'b0);
      for (int i = 0; i < 8; i++) driveLine(d[i]);
      driveLine(parBit);
      driveLine(1'b1);
   endtask
`endif

   // Output side: count flag cycles and compare every accepted word.
   always @(negedge clk) begin
      logic [7:0] expWord;
      if (frameErr === 1'b1) frameErrCycles++;
      if (parErr === 1'b1) parErrCycles++;
      if (overrun === 1'b1) overrunCycles++;
      if (valid === 1'b1 && prevValid !== 1'b1) checkOutput("busyAtValidRise", 32'(busy), 32'd0);
      if (valid === 1'b1) validCycles++;
      if (valid === 1'b1 && ready === 1'b1) begin
         checkOutput("sbHasEntry", 32'(sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) begin
            expWord = sbQ.pop_front();
            checkOutput("rxData", 32'(rxData), 32'(expWord));
         end
      end
      prevValid = valid;
   end

   initial begin
      int v0, fe0, pe0, ov0;
      rst      = 1'b1;
      rxSerial = 1'b1;
      ready    = 1'b1;
      waitCycles(3);
      checkOutput("rstValid", 32'(valid), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstData", 32'(rxData), 32'd0);
      checkOutput("rstFlags", 32'({frameErr, parErr, overrun}), 32'd0);
      rst = 1'b0;
      waitCycles(5);

      $display("[TB] frame 0xA5 with consumer ready");
      v0 = validCycles; fe0 = frameErrCycles; pe0 = parErrCycles; ov0 = overrunCycles;
      sbQ.push_back(8'hA5);
      applyStimulus(8'hA5, 1'b1);
      waitCycles(10);
      checkOutput("a5ValidCycles", 32'(validCycles - v0), 32'd1);
      checkOutput("a5Flags", 32'((frameErrCycles - fe0) + (parErrCycles - pe0) + (overrunCycles - ov0)), 32'd0);
      checkOutput("a5BusyAfter", 32'(busy), 32'd0);

      $display("[TB] 4-cycle low glitch on idle line");
      v0 = validCycles; fe0 = frameErrCycles; pe0 = parErrCycles; ov0 = overrunCycles;
      rxSerial = 1'b0;
      waitCycles(4);
      rxSerial = 1'b1;
      waitCycles(30);
      checkOutput("glitchValid", 32'(validCycles - v0), 32'd0);
      checkOutput("glitchFlags", 32'((frameErrCycles - fe0) + (parErrCycles - pe0) + (overrunCycles - ov0)), 32'd0);
      checkOutput("glitchBusy", 32'(busy), 32'd0);

      $display("[TB] frame 0x3C with low stop bit, then break");
      v0 = validCycles; fe0 = frameErrCycles;
      applyStimulus(8'h3C, 1'b0);
      waitCycles(40);
      checkOutput("breakFrameErr", 32'(frameErrCycles - fe0), 32'd1);
      checkOutput("breakValid", 32'(validCycles - v0), 32'd0);
      checkOutput("breakBusyHeld", 32'(busy), 32'd1);
      rxSerial = 1'b1;
      waitCycles(20);
      checkOutput("breakBusyReleased", 32'(busy), 32'd0);
      checkOutput("breakNoNewFrame", 32'(validCycles - v0), 32'd0);

      $display("[TB] back-to-back 0x11, 0x22 with consumer stalled");
      ov0   = overrunCycles;
      ready = 1'b0;
      sbQ.push_back(8'h11);
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      waitCycles(10);
      checkOutput("stallValid", 32'(valid), 32'd1);
      checkOutput("stallData", 32'(rxData), 32'h11);
      checkOutput("stallOverrun", 32'(overrunCycles - ov0), 32'd1);
      ready = 1'b1;
      waitCycles(5);
      checkOutput("drainValid", 32'(valid), 32'd0);
      checkOutput("drainSbEmpty", 32'(sbQ.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity frames 0x07");
      v0 = validCycles; pe0 = parErrCycles;
      sbQ.push_back(8'h07);
      sendParFrame(8'h07, 1'b1);
      waitCycles(10);
      checkOutput("parGoodValid", 32'(validCycles - v0), 32'd1);
      checkOutput("parGoodErr", 32'(parErrCycles - pe0), 32'd0);
      v0 = validCycles;
      sendParFrame(8'h07, 1'b0);
      waitCycles(10);
      checkOutput("parBadErr", 32'(parErrCycles - pe0), 32'd1);
      checkOutput("parBadValid", 32'(validCycles - v0), 32'd0);
`endif

      $display("[TB] reset during data bits of 0x5A, then 0xC3");
      fe0 = frameErrCycles; pe0 = parErrCycles; ov0 = overrunCycles;
      driveLine(1'b0);
      driveLine(1'b0);
      driveLine(1'b1);
      rxSerial = 1'b0;
      waitCycles(8);
      checkOutput("preRstBusy", 32'(busy), 32'd1);
      rst      = 1'b1;
      rxSerial = 1'b1;
      waitCycles(1);
      checkOutput("midRstValid", 32'(valid), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstData", 32'(rxData), 32'd0);
      checkOutput("midRstFlags", 32'({frameErr, parErr, overrun}), 32'd0);
      rst = 1'b0;
      waitCycles(30);
      v0 = validCycles;
      checkOutput("postRstBusy", 32'(busy), 32'd0);
      sbQ.push_back(8'hC3);
      applyStimulus(8'hC3, 1'b1);
      waitCycles(10);
      checkOutput("c3ValidCycles", 32'(validCycles - v0), 32'd1);
      checkOutput("c3Flags", 32'((frameErrCycles - fe0) + (parErrCycles - pe0) + (overrunCycles - ov0)), 32'd0);

      checkOutput("sbEmptyAtEnd", 32'(sbQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, i_clk cycles per serial bit, legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 = even, 1 = odd); used only with UART_RX_PARITY_EN.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port i_rx_serial  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port i_ready  input  1  consumer accepts o_rx_data when high with o_valid.
REQ-010 SHALL have port o_rx_data  output  DATA_BITS  received word, LSB is first bit on line.
REQ-011 SHALL have port o_valid  output  1  o_rx_data holds an unconsumed word.
REQ-012 SHALL have port o_busy  output  1  frame reception in progress (state not IDLE).
REQ-013 SHALL have port o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-014 SHALL have port o_par_err  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN).
REQ-015 SHALL have port o_overrun  output  1  one-cycle pulse: good frame completed while o_valid high.

Function
REQ-016 SHALL pass i_rx_serial through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-018 IDLE -> START on synchronized line low; the bit counter is loaded to 0.
REQ-019 START: at count CLKS_PER_BIT/2 (integer division), line low -> DATA with counter reset; line high -> IDLE (glitch rejected, no flag).
REQ-020 DATA: sample at every CLKS_PER_BIT count; shift LSB-first; after DATA_BITS samples -> PARITY if UART_RX_PARITY_EN, else STOP.
REQ-021 PARITY: sample one bit at CLKS_PER_BIT; compare against the XOR of the data bits XOR PARITY_ODD; -> STOP.
REQ-022 STOP: sample STOP_BITS bits, each at CLKS_PER_BIT; any low sample -> o_frame_err pulse, word discarded, -> WAIT_IDLE.
REQ-023 WAIT_IDLE SHALL hold until the line is high, then -> IDLE (break condition tolerated).
REQ-024 On a good final stop sample: one cycle later o_valid=1 and o_rx_data updated, -> IDLE; the next start bit can be detected on that same cycle.
REQ-025 On parity error: o_par_err pulses in the cycle o_valid would have risen; word discarded; o_frame_err takes precedence if both occur.
REQ-026 o_valid SHALL stay high and o_rx_data stable until a cycle with i_ready=1; o_valid clears on the next edge.
REQ-027 A good frame completing while o_valid=1 and i_ready=0 SHALL pulse o_overrun and drop the new word; if i_ready=1 in that cycle, the new word loads and o_valid stays 1.
REQ-028 The bit counter SHALL be $clog2(CLKS_PER_BIT+1) bits wide and never wrap within a bit.

Reset
REQ-029 i_rst SHALL force IDLE, counters 0, synchronizer flops 1, o_rx_data 0, and all flags and o_valid/o_busy 0 on the next edge, including mid-frame; no error flag is raised for the aborted frame.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: the PARITY state and o_par_err are active; undefined: PARITY is never entered, frame = start + DATA_BITS + STOP_BITS, o_par_err constant 0.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum type uart_rx_state_t and parameter-range constants shared with a future uart_tx_param.
REQ-032 One sub-module uart_bit_timer SHALL provide the per-bit counter with half-bit and full-bit strobes.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-033 Frame 0xA5, i_ready=1 -> o_valid for 1 cycle with o_rx_data=0xA5, no flags; o_busy low 1 cycle after the stop sample.
REQ-034 Low glitch of 4 cycles on idle line -> back to IDLE, no o_valid, no flags.
REQ-035 Frame 0x3C with stop bit low -> o_frame_err pulse, no o_valid; line then held low 40 cycles -> no new frame until the line goes high.
REQ-036 Frames 0x11 then 0x22 back-to-back, i_ready=0 -> o_rx_data=0x11 held, o_overrun pulses once; i_ready=1 then yields 0x11 only.
REQ-037 With UART_RX_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity bit 1 -> valid 0x07; same frame with parity bit 0 -> o_par_err pulse, no o_valid.
REQ-038 i_rst asserted 1 cycle during the DATA state of frame 0x5A -> all outputs 0, IDLE; a following frame 0xC3 is received correctly.
